fourstate_frame_deser: RTL and testbench

- Receive end of the four-state serial frame link; the companion serializer is the transmit end.
- Accepts one 2-bit symbol per cycle and reassembles a frame of ELEMS four-state elements into a parallel value/unknown-mask pair.
- Presents the frame through a single-slot valid/ready output buffer.
- Sits between the link and generated stimulus/checker logic that consumes wide multi-dimensional four-state vectors.

---
 rtl/fourstate_link_pkg.sv | 23 ++
 rtl/fourstate_sym_decode.sv | 12 +
 rtl/fourstate_frame_deser.sv | 121 ++++++++++++
 tb/tb_fourstate_frame_deser.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fourstate_link_pkg.sv
// Definitions shared by both ends of the four-state serial frame link.
// Symbol encoding, receive FSM states and the symbol-to-{val,unk} decode.
package fourstate_link_pkg;

  typedef enum logic [1:0] {
    SYM_0 = 2'b00,
    SYM_1 = 2'b01,
    SYM_Z = 2'b10,
    SYM_X = 2'b11
  } sym_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } deser_state_t;

  // Bit 0 of the symbol carries the value, bit 1 flags z/x.
  function automatic logic [1:0] sym_decode(input sym_t s);
    return {s[0], s[1]};
  endfunction

endpackage

// File: rtl/fourstate_sym_decode.sv
// Combinational decoder from one link symbol to its {val, unk} pair.
module fourstate_sym_decode
  import fourstate_link_pkg::*;
(
  input  sym_t sym,
  output logic val,
  output logic unk
);

  assign {val, unk} = sym_decode(sym);

endmodule

// File: rtl/fourstate_frame_deser.sv
// Receive end of the four-state frame link: collects ELEMS symbols into a
// value/unknown-mask pair and presents it through a single-slot buffer.
module fourstate_frame_deser
  import fourstate_link_pkg::*;
#(
  parameter int ELEMS = 24,
  parameter int CNT_W = $clog2(ELEMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [1:0]       in_sym,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ELEMS-1:0] out_val,
  output logic [ELEMS-1:0] out_unk,
  output logic [CNT_W-1:0] out_unk_cnt,
  output logic             err_sof
);

  if (ELEMS < 2 || ELEMS > (2 ** CNT_W) - 1) begin : g_bad_size
    $error("fourstate_frame_deser: ELEMS must be >= 2 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ELEMS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  deser_state_t     state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ELEMS-1:0] val_q, val_d;
  logic [ELEMS-1:0] unk_q, unk_d;
  logic             err_q, err_d;
  logic             dec_val, dec_unk;
  logic             acc;

  fourstate_sym_decode u_dec (
    .sym (sym_t'(in_sym)),
    .val (dec_val),
    .unk (dec_unk)
  );

  assign in_ready    = (state_q != HOLD);
  assign out_valid   = (state_q == HOLD);
  assign acc         = in_valid & in_ready;
  assign out_val     = val_q;
  assign out_unk     = unk_q;
  assign out_unk_cnt = cnt_q;
  assign err_sof     = err_q;

  // Next-state: a sof always restarts element 0; staging bits change only on accept.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    unk_d   = unk_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (in_sof) begin
            val_d[0] = dec_val;
            unk_d[0] = dec_unk;
            idx_d    = ONE;
            cnt_d    = CNT_W'(dec_unk);
            state_d  = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (acc) begin
          if (in_sof) begin
            val_d[0] = dec_val;
            unk_d[0] = dec_unk;
            idx_d    = ONE;
            cnt_d    = CNT_W'(dec_unk);
            err_d    = 1'b1;
          end else begin
            val_d[idx_q] = dec_val;
            unk_d[idx_q] = dec_unk;
            cnt_d        = cnt_q + CNT_W'(dec_unk);
            if (idx_q == LAST) begin
              state_d = HOLD;
            end else begin
              idx_d = idx_q + ONE;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and staging registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      unk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      unk_q   <= unk_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fourstate_frame_deser.sv
// Randomized self-checking bench for fourstate_frame_deser against a frame-level model.
module tb_fourstate_frame_deser;

  localparam int ELEMS = 24;
  localparam int CNT_W = $clog2(ELEMS + 1);

  typedef logic [1:0] frame_t [ELEMS];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic [1:0]       in_sym = 2'b00;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ELEMS-1:0] out_val;
  logic [ELEMS-1:0] out_unk;
  logic [CNT_W-1:0] out_unk_cnt;
  logic             err_sof;

  int n_cmp = 0;
  int n_fail = 0;
  int err_pulses = 0;

  fourstate_frame_deser #(.ELEMS(ELEMS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_sym      (in_sym),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_val     (out_val),
    .out_unk     (out_unk),
    .out_unk_cnt (out_unk_cnt),
    .err_sof     (err_sof)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (err_sof === 1'b1) err_pulses++;
  endtask

  // Frame-level model: 0 and z read as value 0, 1 and x as value 1; z and x are unknown.
  function automatic void model(input frame_t f, output logic [ELEMS-1:0] v,
                                output logic [ELEMS-1:0] u, output int c);
    v = '0;
    u = '0;
    c = 0;
    for (int k = 0; k < ELEMS; k++) begin
      v[k] = (f[k] == 2'd1) || (f[k] == 2'd3);
      u[k] = (f[k] == 2'd2) || (f[k] == 2'd3);
      if (u[k]) c++;
    end
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < ELEMS; k++) f[k] = 2'($urandom_range(0, 3));
    return f;
  endfunction

  task automatic send_syms(input frame_t f, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      in_valid = 1'b1;
      in_sof   = (k == 0);
      in_sym   = f[k];
      tick();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_val !== '0) begin n_fail++; $display("FAIL reset_out_val: got %h want 0", out_val); end
    n_cmp++; if (out_unk !== '0) begin n_fail++; $display("FAIL reset_out_unk: got %h want 0", out_unk); end
    n_cmp++; if (out_unk_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", out_unk_cnt); end
    n_cmp++; if (err_sof !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_sof); end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed_frame();
    frame_t f;
    for (int k = 0; k < ELEMS; k++) f[k] = 2'b00;
    f[0] = 2'b01;
    f[ELEMS-1] = 2'b11;
    err_pulses = 0;
    out_ready = 1'b1;
    send_syms(f, 0, ELEMS - 2);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_early_valid: got %b want 0", out_valid); end
    send_syms(f, ELEMS - 1, ELEMS - 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_val !== 24'h800001) begin n_fail++; $display("FAIL dir_val: got %h want 800001", out_val); end
    n_cmp++; if (out_unk !== 24'h800000) begin n_fail++; $display("FAIL dir_unk: got %h want 800000", out_unk); end
    n_cmp++; if (out_unk_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL dir_cnt: got %0d want 1", out_unk_cnt); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_valid_drop: got %b want 0", out_valid); end
    n_cmp++; if (err_pulses !== 0) begin n_fail++; $display("FAIL dir_err: got %0d pulses want 0", err_pulses); end
    out_ready = 1'b0;
  endtask

  task automatic test_hold_backpressure();
    frame_t f;
    frame_t g;
    logic [ELEMS-1:0] v, u;
    int c;
    for (int k = 0; k < ELEMS; k++) f[k] = 2'b10;
    err_pulses = 0;
    out_ready = 1'b0;
    send_syms(f, 0, ELEMS - 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sof   = 1'b1;
      in_sym   = 2'($urandom_range(0, 3));
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (out_val !== '0) begin n_fail++; $display("FAIL hold_val[%0d]: got %h want 0", i, out_val); end
      n_cmp++; if (out_unk !== 24'hFFFFFF) begin n_fail++; $display("FAIL hold_unk[%0d]: got %h want ffffff", i, out_unk); end
      n_cmp++; if (out_unk_cnt !== CNT_W'(24)) begin n_fail++; $display("FAIL hold_cnt[%0d]: got %0d want 24", i, out_unk_cnt); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", out_valid); end
    n_cmp++; if (err_pulses !== 0) begin n_fail++; $display("FAIL hold_err: got %0d pulses want 0", err_pulses); end
    g = rand_frame();
    model(g, v, u, c);
    send_syms(g, 0, ELEMS - 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_next_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_val !== v) begin n_fail++; $display("FAIL hold_next_val: got %h want %h", out_val, v); end
    n_cmp++; if (out_unk !== u) begin n_fail++; $display("FAIL hold_next_unk: got %h want %h", out_unk, u); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_idle_err();
    err_pulses = 0;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_sym   = 2'b01;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (err_sof !== 1'b1) begin n_fail++; $display("FAIL idle_err_pulse: got %b want 1", err_sof); end
    tick();
    n_cmp++; if (err_sof !== 1'b0) begin n_fail++; $display("FAIL idle_err_clear: got %b want 0", err_sof); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_err_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_err_ready: got %b want 1", in_ready); end
    in_valid = 1'b1;
    in_sym   = 2'($urandom_range(0, 3));
    tick();
    n_cmp++; if (err_sof !== 1'b1) begin n_fail++; $display("FAIL idle_b2b_first: got %b want 1", err_sof); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (err_sof !== 1'b1) begin n_fail++; $display("FAIL idle_b2b_second: got %b want 1", err_sof); end
    tick();
    n_cmp++; if (err_pulses !== 3) begin n_fail++; $display("FAIL idle_err_count: got %0d want 3", err_pulses); end
  endtask

  task automatic test_resync();
    frame_t a;
    frame_t b;
    a = rand_frame();
    for (int k = 0; k < ELEMS; k++) b[k] = 2'b00;
    b[0] = 2'b11;
    err_pulses = 0;
    out_ready = 1'b0;
    send_syms(a, 0, 9);
    send_syms(b, 0, ELEMS - 1);
    n_cmp++; if (err_pulses !== 1) begin n_fail++; $display("FAIL resync_err: got %0d pulses want 1", err_pulses); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL resync_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_val !== 24'h000001) begin n_fail++; $display("FAIL resync_val: got %h want 000001", out_val); end
    n_cmp++; if (out_unk !== 24'h000001) begin n_fail++; $display("FAIL resync_unk: got %h want 000001", out_unk); end
    n_cmp++; if (out_unk_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL resync_cnt: got %0d want 1", out_unk_cnt); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    frame_t f;
    frame_t g;
    logic [ELEMS-1:0] v, u;
    int c;
    for (int ph = 0; ph < 2; ph++) begin
      f = rand_frame();
      out_ready = 1'b0;
      send_syms(f, 0, (ph == 0) ? 11 : ELEMS - 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid%0d_valid: got %b want 0", ph, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid%0d_ready: got %b want 1", ph, in_ready); end
      n_cmp++; if (out_val !== '0) begin n_fail++; $display("FAIL rstmid%0d_val: got %h want 0", ph, out_val); end
      n_cmp++; if (out_unk !== '0) begin n_fail++; $display("FAIL rstmid%0d_unk: got %h want 0", ph, out_unk); end
      n_cmp++; if (out_unk_cnt !== '0) begin n_fail++; $display("FAIL rstmid%0d_cnt: got %0d want 0", ph, out_unk_cnt); end
      n_cmp++; if (err_sof !== 1'b0) begin n_fail++; $display("FAIL rstmid%0d_err: got %b want 0", ph, err_sof); end
      g = rand_frame();
      model(g, v, u, c);
      err_pulses = 0;
      send_syms(g, 0, ELEMS - 1);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid%0d_next_valid: got %b want 1", ph, out_valid); end
      n_cmp++; if (out_val !== v) begin n_fail++; $display("FAIL rstmid%0d_next_val: got %h want %h", ph, out_val, v); end
      n_cmp++; if (out_unk !== u) begin n_fail++; $display("FAIL rstmid%0d_next_unk: got %h want %h", ph, out_unk, u); end
      n_cmp++; if (out_unk_cnt !== CNT_W'(c)) begin n_fail++; $display("FAIL rstmid%0d_next_cnt: got %0d want %0d", ph, out_unk_cnt, c); end
      n_cmp++; if (err_pulses !== 0) begin n_fail++; $display("FAIL rstmid%0d_next_err: got %0d want 0", ph, err_pulses); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_random_frames();
    frame_t f;
    logic [ELEMS-1:0] v, u;
    int c;
    int w;
    for (int n = 0; n < 6; n++) begin
      f = rand_frame();
      model(f, v, u, c);
      err_pulses = 0;
      out_ready = 1'b0;
      send_syms(f, 0, ELEMS - 1);
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_valid: got %b want 1", n, out_valid); end
      n_cmp++; if (out_val !== v) begin n_fail++; $display("FAIL rnd%0d_val: got %h want %h", n, out_val, v); end
      n_cmp++; if (out_unk !== u) begin n_fail++; $display("FAIL rnd%0d_unk: got %h want %h", n, out_unk, u); end
      n_cmp++; if (out_unk_cnt !== CNT_W'(c)) begin n_fail++; $display("FAIL rnd%0d_cnt: got %0d want %0d", n, out_unk_cnt, c); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_drop: got %b want 0", n, out_valid); end
      n_cmp++; if (err_pulses !== 0) begin n_fail++; $display("FAIL rnd%0d_err: got %0d want 0", n, err_pulses); end
    end
  endtask

  task automatic test_back_to_back();
    localparam int NF = 4;
    frame_t fr [NF];
    logic [ELEMS-1:0] v, u;
    int c;
    int ptr = 0;
    int got = 0;
    int low = 0;
    int cyc = 0;
    logic acc;
    for (int i = 0; i < NF; i++) fr[i] = rand_frame();
    err_pulses = 0;
    out_ready = 1'b1;
    while (got < NF && cyc < NF * (ELEMS + 4)) begin
      if (ptr < NF * ELEMS) begin
        in_valid = 1'b1;
        in_sof   = (ptr % ELEMS == 0);
        in_sym   = fr[ptr / ELEMS][ptr % ELEMS];
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
      acc = in_valid && in_ready;
      if (in_ready !== 1'b1) low++;
      tick();
      cyc++;
      if (acc) ptr++;
      if (out_valid === 1'b1) begin
        model(fr[got], v, u, c);
        n_cmp++; if (out_val !== v) begin n_fail++; $display("FAIL b2b%0d_val: got %h want %h", got, out_val, v); end
        n_cmp++; if (out_unk !== u) begin n_fail++; $display("FAIL b2b%0d_unk: got %h want %h", got, out_unk, u); end
        n_cmp++; if (out_unk_cnt !== CNT_W'(c)) begin n_fail++; $display("FAIL b2b%0d_cnt: got %0d want %0d", got, out_unk_cnt, c); end
        got++;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (got !== NF) begin n_fail++; $display("FAIL b2b_frames: got %0d want %0d", got, NF); end
    n_cmp++; if (low !== NF - 1) begin n_fail++; $display("FAIL b2b_ready_low: got %0d want %0d", low, NF - 1); end
    n_cmp++; if (cyc !== NF * ELEMS + NF - 1) begin n_fail++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, NF * ELEMS + NF - 1); end
    n_cmp++; if (err_pulses !== 0) begin n_fail++; $display("FAIL b2b_err: got %0d want 0", err_pulses); end
  endtask

  initial begin
    test_reset();
    test_directed_frame();
    test_hold_backpressure();
    test_idle_err();
    test_resync();
    test_reset_mid();
    test_random_frames();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
